column_accumulator: RTL and testbench



---
 rtl/npu_pkg.sv | 13 +
 rtl/col_popcount.sv | 18 +
 rtl/column_accumulator.sv | 151 +++++++++++++++
 tb/tb_column_accumulator.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU datapath constants: default column-interface geometry and the
// signed saturation limits of the 32-bit accumulator.
package npu_pkg;

  localparam int COLS_DEF  = 19;
  localparam int DEPTH_DEF = 48;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W     = 6;

  localparam logic [ACC_W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [ACC_W_DEF-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/col_popcount.sv
// Combinational population count of one partial-product column.
module col_popcount
  import npu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0] col,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(col[i]);
    end
  end

endmodule

// File: rtl/column_accumulator.sv
// Reduces weighted bit-column frames to signed sums and accumulates them until a
// last frame. Define ACC_SAT_EN for saturating accumulation with a sticky out_sat.
module column_accumulator
  import npu_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLS*DEPTH-1:0] in_cols,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SUM_W = COLS + CNT_W;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: per-column popcounts
  logic [CNT_W-1:0] pc   [COLS];
  logic [CNT_W-1:0] cnt1 [COLS];
  logic             valid1, last1;

  for (genvar g = 0; g < COLS; g++) begin : g_pop
    col_popcount #(.DEPTH(DEPTH)) u_pop (
      .col (in_cols[g*DEPTH +: DEPTH]),
      .cnt (pc[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      last1  <= 1'b0;
      for (int k = 0; k < COLS; k++) cnt1[k] <= '0;
    end else if (adv) begin
      valid1 <= in_valid;
      last1  <= in_last;
      cnt1   <= pc;
    end
  end

  // S2: weight and truncate; the upstream sign constants make the low COLS bits exact
  logic [SUM_W-1:0] wsum;
  logic [COLS-1:0]  frame2;
  logic             valid2, last2;

  always_comb begin
    wsum = '0;
    for (int k = 0; k < COLS; k++) begin
      wsum = wsum + (SUM_W'(cnt1[k]) << k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame2 <= '0;
      valid2 <= 1'b0;
      last2  <= 1'b0;
    end else if (adv) begin
      frame2 <= wsum[COLS-1:0];
      valid2 <= valid1;
      last2  <= last1;
    end
  end

  // S3: accumulate onto zero for the first frame of a group
  logic [ACC_W-1:0] ext, base, sum_raw, acc_d, acc;
  logic             first, valid3, last3;

  assign ext     = {{(ACC_W-COLS){frame2[COLS-1]}}, frame2};
  assign base    = first ? '0 : acc;
  assign sum_raw = base + ext;

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf, sat_d, sat_run;

  always_comb begin
    ovf   = (base[ACC_W-1] == ext[ACC_W-1]) && (sum_raw[ACC_W-1] != base[ACC_W-1]);
    acc_d = sum_raw;
    if (ovf) acc_d = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
    sat_d = (first ? 1'b0 : sat_run) | ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_run <= 1'b0;
    end else if (adv && valid2) begin
      sat_run <= sat_d;
    end
  end
`else
  assign acc_d = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      first  <= 1'b1;
      valid3 <= 1'b0;
      last3  <= 1'b0;
    end else if (adv) begin
      valid3 <= valid2;
      last3  <= last2;
      if (valid2) begin
        acc   <= acc_d;
        first <= last2;
      end
    end
  end

  // Output register: a new result may replace one being consumed on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (valid3 && last3) begin
        out_data  <= acc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ACC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= 1'b0;
    end else if (adv && valid3 && last3) begin
      out_sat <= sat_run;
    end
  end
`else
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_column_accumulator.sv
// Randomized self-checking bench for column_accumulator with an arithmetic
// reference model and an output scoreboard; honours ACC_SAT_EN when defined.
module tb_column_accumulator;
  import npu_pkg::*;

  localparam int COLS  = COLS_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int ACC_W = ACC_W_DEF;
  localparam int FW    = COLS * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [FW-1:0]    in_cols = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [ACC_W-1:0] exp_data [$];
  logic             exp_sat  [$];
  longint           m_acc;
  bit               m_first;
  bit               m_sat;
  bit               rand_ready = 1'b0;

  column_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_cols   (in_cols),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: every consumed result must match the next modelled result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_data.size() == 0) begin
        $display("[TB] FAIL unexpected_output: got %h want none", out_data);
        n_fail++;
      end else begin
        if (out_data !== exp_data[0] || out_sat !== exp_sat[0]) begin
          $display("[TB] FAIL scoreboard: got data %h sat %b want data %h sat %b",
                   out_data, out_sat, exp_data[0], exp_sat[0]);
          n_fail++;
        end
        void'(exp_data.pop_front());
        void'(exp_sat.pop_front());
      end
    end
  end

  function automatic int frame_value(input logic [FW-1:0] c);
    longint s = 0;
    for (int k = 0; k < COLS; k++) begin
      s += longint'($countones(c[k*DEPTH +: DEPTH])) << k;
    end
    s = s & ((longint'(1) << COLS) - 1);
    if (s >= (longint'(1) << (COLS - 1))) s -= (longint'(1) << COLS);
    return int'(s);
  endfunction

  function automatic logic [FW-1:0] cols_of(input int v);
    logic [FW-1:0] c = '0;
    for (int k = 0; k < COLS; k++) c[k*DEPTH] = v[k];
    return c;
  endfunction

  task automatic model_reset();
    m_acc   = 0;
    m_first = 1'b1;
    m_sat   = 1'b0;
    exp_data.delete();
    exp_sat.delete();
  endtask

  task automatic model_accept(input int f, input bit last);
    longint s;
    bit     sat;
    logic signed [ACC_W-1:0] t;
    s   = (m_first ? 0 : m_acc) + longint'(f);
    sat = m_first ? 1'b0 : m_sat;
`ifdef ACC_SAT_EN
    if (s > (longint'(1) << (ACC_W - 1)) - 1) begin
      s = (longint'(1) << (ACC_W - 1)) - 1;
      sat = 1'b1;
    end else if (s < -(longint'(1) << (ACC_W - 1))) begin
      s = -(longint'(1) << (ACC_W - 1));
      sat = 1'b1;
    end
`else
    t = s[ACC_W-1:0];
    s = t;
`endif
    m_acc = s;
    if (last) begin
      exp_data.push_back(s[ACC_W-1:0]);
      exp_sat.push_back(sat);
    end
    m_first = last;
    m_sat   = sat;
  endtask

  task automatic send_frame(input logic [FW-1:0] c, input bit last);
    bit done = 1'b0;
    int waited = 0;
    in_cols  = c;
    in_last  = last;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        model_accept(frame_value(c), last);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
        if (waited > 200) begin
          $display("[TB] FAIL accept_timeout: got in_ready %b want 1", in_ready);
          n_cmp++;
          n_fail++;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_cols  = '0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("[TB] FAIL result_timeout: got out_valid %b want 1", out_valid);
      n_cmp++;
      n_fail++;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_data.size() != 0 || out_valid === 1'b1) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      $display("[TB] FAIL drain_timeout: got %0d pending want 0", exp_data.size());
      n_cmp++;
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    out_ready = 1'b0;
    model_reset();
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); n_fail++; end
    if (out_data !== '0) begin $display("[TB] FAIL reset_out_data: got %h want 0", out_data); n_fail++; end
    if (out_sat !== 1'b0) begin $display("[TB] FAIL reset_out_sat: got %b want 0", out_sat); n_fail++; end
    if (in_ready !== 1'b1) begin $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); n_fail++; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [FW-1:0] c = '0;
    c[0] = 1'b1; c[1] = 1'b1; c[2] = 1'b1;
    c[2*DEPTH] = 1'b1;
    out_ready = 1'b0;
    send_frame(c, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        $display("[TB] FAIL latency_early[%0d]: got out_valid %b want 0", i, out_valid);
        n_fail++;
      end
    end
    @(negedge clk);
    n_cmp += 3;
    if (out_valid !== 1'b1) begin $display("[TB] FAIL latency_valid: got %b want 1", out_valid); n_fail++; end
    if (out_data !== 32'd7) begin $display("[TB] FAIL single_data: got %h want 00000007", out_data); n_fail++; end
    if (out_sat !== 1'b0) begin $display("[TB] FAIL single_sat: got %b want 0", out_sat); n_fail++; end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
  endtask

  task automatic test_negative();
    bit ok;
    out_ready = 1'b1;
    send_frame(cols_of(-1), 1'b1);
    idle();
    wait_result(ok);
    if (ok) begin
      n_cmp++;
      if (out_data !== 32'hFFFF_FFFF) begin
        $display("[TB] FAIL negative_data: got %h want ffffffff", out_data);
        n_fail++;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b1;
    send_frame(cols_of(7), 1'b0);
    send_frame(cols_of(7), 1'b0);
    send_frame(cols_of(7), 1'b1);
    send_frame(cols_of(7), 1'b1);
    idle();
    wait_result(ok);
    if (ok) begin
      n_cmp++;
      if (out_data !== 32'd21) begin $display("[TB] FAIL accum_data: got %h want 00000015", out_data); n_fail++; end
      @(negedge clk);
      n_cmp += 2;
      if (out_valid !== 1'b1) begin $display("[TB] FAIL restart_valid: got %b want 1", out_valid); n_fail++; end
      if (out_data !== 32'd7) begin $display("[TB] FAIL restart_data: got %h want 00000007", out_data); n_fail++; end
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    fork
      begin
        send_frame(cols_of(100), 1'b1);
        send_frame(cols_of(-50), 1'b1);
        send_frame(cols_of(30), 1'b0);
        send_frame(cols_of(12), 1'b1);
        idle();
      end
      begin
        logic [ACC_W-1:0] held;
        bit seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
          @(negedge clk);
          if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
          $display("[TB] FAIL bp_result_timeout: got out_valid 0 want 1");
          n_fail++;
        end else begin
          held = out_data;
          if (held !== 32'd100) begin $display("[TB] FAIL bp_first_data: got %h want 00000064", held); n_fail++; end
          for (int i = 0; i < 5; i++) begin
            n_cmp += 2;
            if (in_ready !== 1'b0) begin $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); n_fail++; end
            if (out_valid !== 1'b1 || out_data !== held) begin
              $display("[TB] FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, held);
              n_fail++;
            end
            @(negedge clk);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random();
    logic [FW-1:0] c;
    logic [63:0]   r;
    bit            last;
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < COLS; k++) begin
        r = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r = r & {$urandom, $urandom};
        c[k*DEPTH +: DEPTH] = r[DEPTH-1:0];
      end
      last = (i == 79) || ($urandom_range(0, 2) == 0);
      send_frame(c, last);
    end
    idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
  endtask

  task automatic test_overflow();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 8193; i++) begin
      send_frame(cols_of(-262144), i == 8192);
    end
    idle();
    wait_result(ok);
    if (ok) begin
      n_cmp += 2;
`ifdef ACC_SAT_EN
      if (out_data !== 32'h8000_0000) begin $display("[TB] FAIL overflow_data: got %h want 80000000", out_data); n_fail++; end
      if (out_sat !== 1'b1) begin $display("[TB] FAIL overflow_sat: got %b want 1", out_sat); n_fail++; end
`else
      if (out_data !== 32'h7FFC_0000) begin $display("[TB] FAIL overflow_data: got %h want 7ffc0000", out_data); n_fail++; end
      if (out_sat !== 1'b0) begin $display("[TB] FAIL overflow_sat: got %b want 0", out_sat); n_fail++; end
`endif
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    send_frame(cols_of(9), 1'b0);
    send_frame(cols_of(9), 1'b0);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin $display("[TB] FAIL mid_reset_valid: got %b want 0", out_valid); n_fail++; end
    if (out_data !== '0) begin $display("[TB] FAIL mid_reset_data: got %h want 0", out_data); n_fail++; end
    if (out_sat !== 1'b0) begin $display("[TB] FAIL mid_reset_sat: got %b want 0", out_sat); n_fail++; end
    if (in_ready !== 1'b1) begin $display("[TB] FAIL mid_reset_ready: got %b want 1", in_ready); n_fail++; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(cols_of(5), 1'b1);
    idle();
    wait_result(ok);
    if (ok) begin
      n_cmp++;
      if (out_data !== 32'd5) begin $display("[TB] FAIL mid_reset_result: got %h want 00000005", out_data); n_fail++; end
    end
    drain();
  endtask

  initial begin
    $display("[TB] column_accumulator bench start");
    test_reset();
    test_single();
    test_negative();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
